// File: rtl/sad_datapath.sv
// SAD engine datapath: issues N element-pair reads, forms |A-B| in a two-stage
// registered pipeline, accumulates the terms and loads the sum on command.
module sad_datapath #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 8,
  parameter int unsigned N  = 256,
  parameter int unsigned SW = 16
) (
  input  logic          clk,
  input  logic          Mrst,
  input  logic          rst,
  input  logic          en,
  input  logic          en_reg,
  input  logic [DW-1:0] a_data,
  input  logic [DW-1:0] b_data,
  output logic [AW-1:0] addr,
  output logic          comp,
  output logic [SW-1:0] sad,
  output logic          sad_valid
);

  // One extra counter bit so the count can reach N == 2^AW without wrapping.
  localparam int unsigned IW = AW + 1;
  localparam logic [IW-1:0] N_I = IW'(N);

  logic [IW-1:0] i_q, i_d;
  logic          v1_q, v1_d;
  logic          v2_q, v2_d;
  logic [DW-1:0] diff_q, diff_d;
  logic [SW-1:0] acc_q, acc_d;
  logic [SW-1:0] sad_d;
  logic          sad_valid_d;
  logic          issue_c;
  logic [DW-1:0] abs_c;

  assign issue_c = en && (i_q < N_I);
  assign abs_c   = (a_data >= b_data) ? (a_data - b_data) : (b_data - a_data);

  // Next-state: issue, stage 1, stage 2, then synchronous clear overrides the
  // pipeline; the result load sees the pre-clear accumulator.
  always_comb begin
    i_d         = i_q;
    v1_d        = 1'b0;
    v2_d        = v1_q;
    diff_d      = diff_q;
    acc_d       = acc_q;
    sad_d       = sad;
    sad_valid_d = 1'b0;

    if (issue_c) begin
      i_d  = i_q + IW'(1);
      v1_d = 1'b1;
    end
    if (v1_q) begin
      diff_d = abs_c;
    end
    if (v2_q) begin
      acc_d = acc_q + SW'(diff_q);
    end
    if (rst) begin
      i_d    = '0;
      v1_d   = 1'b0;
      v2_d   = 1'b0;
      diff_d = '0;
      acc_d  = '0;
    end
    if (en_reg) begin
      sad_d       = acc_q;
      sad_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge Mrst) begin
    if (!Mrst) begin
      i_q       <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      diff_q    <= '0;
      acc_q     <= '0;
      sad       <= '0;
      sad_valid <= 1'b0;
    end else begin
      i_q       <= i_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      diff_q    <= diff_d;
      acc_q     <= acc_d;
      sad       <= sad_d;
      sad_valid <= sad_valid_d;
    end
  end

  // Address and completion are combinational views of the registered state.
  assign addr = i_q[AW-1:0];
  assign comp = (i_q == N_I) && !v1_q && !v2_q;

endmodule

// File: tb/tb_sad_datapath.sv
// Directed bench for sad_datapath with a synchronous-read memory model.
module tb_sad_datapath;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;
  localparam int unsigned N  = 256;
  localparam int unsigned SW = 16;

  logic          clk = 1'b0;
  logic          Mrst = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          en_reg = 1'b0;
  logic [DW-1:0] a_data;
  logic [DW-1:0] b_data;
  logic [AW-1:0] addr;
  logic          comp;
  logic [SW-1:0] sad;
  logic          sad_valid;

  logic [DW-1:0] mem_a [N];
  logic [DW-1:0] mem_b [N];

  int n_checks = 0;
  int n_fail   = 0;

  sad_datapath #(.DW(DW), .AW(AW), .N(N), .SW(SW)) dut (
    .clk(clk), .Mrst(Mrst), .rst(rst), .en(en), .en_reg(en_reg),
    .a_data(a_data), .b_data(b_data), .addr(addr), .comp(comp),
    .sad(sad), .sad_valid(sad_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    a_data <= mem_a[addr];
    b_data <= mem_b[addr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // mode 0: ramp A=i,B=0; 1: A=0,B=FF; 2: A=FF,B=0
  task automatic load_mem(input int mode);
    for (int k = 0; k < int'(N); k++) begin
      case (mode)
        0: begin mem_a[k] = DW'(k); mem_b[k] = '0; end
        1: begin mem_a[k] = '0; mem_b[k] = 8'hFF; end
        default: begin mem_a[k] = 8'hFF; mem_b[k] = '0; end
      endcase
    end
  endtask

  task automatic clear_block;
    en  = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_load;
    en_reg = 1'b1;
    tick();
    en_reg = 1'b0;
  endtask

  // Drives en (continuous or alternating) until comp is seen or budget expires.
  task automatic run_block(input bit stall, output int issues,
                           output int last_issue, output int comp_edge);
    logic [AW-1:0] prev;
    int k;
    issues = 0;
    last_issue = 0;
    comp_edge = 0;
    prev = addr;
    k = 0;
    while (comp_edge == 0 && k < 2000) begin
      k++;
      en = stall ? 1'(k % 2) : 1'b1;
      tick();
      if (addr !== prev) begin
        issues++;
        last_issue = k;
        prev = addr;
      end
      if (comp === 1'b1) comp_edge = k;
    end
    en = 1'b0;
  endtask

  task automatic test_reset;
    for (int c = 0; c < 6; c++) begin
      rst = c[0];
      en  = ~c[1];
      tick();
      n_checks++;
      if ({addr, comp, sad, sad_valid} !== '0) begin
        n_fail++;
        $display("FAIL reset_hold: addr=%0d comp=%0b sad=%0d sad_valid=%0b required all 0",
                 addr, comp, sad, sad_valid);
      end
    end
    rst = 1'b0;
    en  = 1'b0;
    Mrst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if ({addr, comp, sad, sad_valid} !== '0) begin
        n_fail++;
        $display("FAIL reset_release: addr=%0d comp=%0b sad=%0d sad_valid=%0b required all 0",
                 addr, comp, sad, sad_valid);
      end
    end
  endtask

  task automatic test_ramp;
    int iss, last, ce;
    load_mem(0);
    clear_block();
    run_block(1'b0, iss, last, ce);
    n_checks++;
    if (iss !== 256 || last !== 256) begin
      n_fail++;
      $display("FAIL ramp_issues: got %0d issues last at edge %0d, required 256 at edge 256", iss, last);
    end
    n_checks++;
    if (ce !== 258) begin
      n_fail++;
      $display("FAIL ramp_comp_edge: got %0d required 258", ce);
    end
    pulse_load();
    n_checks++;
    if (sad !== 16'd32640 || sad_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ramp_sad: got sad=%0d valid=%0b required 32640/1", sad, sad_valid);
    end
    tick();
    n_checks++;
    if (sad_valid !== 1'b0 || sad !== 16'd32640) begin
      n_fail++;
      $display("FAIL ramp_valid_pulse: got sad=%0d valid=%0b required 32640/0", sad, sad_valid);
    end
  endtask

  task automatic test_saturation;
    int iss, last, ce;
    for (int m = 1; m <= 2; m++) begin
      load_mem(m);
      clear_block();
      run_block(1'b0, iss, last, ce);
      pulse_load();
      n_checks++;
      if (sad !== 16'd65280 || sad_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL saturation_mode%0d: got sad=%0d valid=%0b required 65280/1", m, sad, sad_valid);
      end
    end
  endtask

  task automatic test_stall;
    int iss, last, ce;
    load_mem(0);
    clear_block();
    run_block(1'b1, iss, last, ce);
    n_checks++;
    if (iss !== 256 || last !== 511) begin
      n_fail++;
      $display("FAIL stall_issues: got %0d issues last at edge %0d, required 256 at edge 511", iss, last);
    end
    n_checks++;
    if (ce !== 513) begin
      n_fail++;
      $display("FAIL stall_comp_edge: got %0d required 513", ce);
    end
    en = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if (addr !== 8'd0 || comp !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold: got addr=%0d comp=%0b required 0/1", addr, comp);
      end
    end
    en = 1'b0;
    pulse_load();
    n_checks++;
    if (sad !== 16'd32640) begin
      n_fail++;
      $display("FAIL stall_sad: got %0d required 32640", sad);
    end
  endtask

  task automatic test_mid_clear;
    int iss, last, ce;
    load_mem(0);
    clear_block();
    en = 1'b1;
    repeat (100) tick();
    n_checks++;
    if (addr !== 8'd100) begin
      n_fail++;
      $display("FAIL mid_clear_addr: got %0d required 100", addr);
    end
    rst = 1'b1;
    en_reg = 1'b1;
    tick();
    rst = 1'b0;
    en_reg = 1'b0;
    en = 1'b0;
    // terms 0..97 accumulated by edge 100: 97*98/2
    n_checks++;
    if (sad !== 16'd4753 || sad_valid !== 1'b1 || addr !== 8'd0 || comp !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_clear_sad: got sad=%0d valid=%0b addr=%0d comp=%0b required 4753/1/0/0",
               sad, sad_valid, addr, comp);
    end
    run_block(1'b0, iss, last, ce);
    n_checks++;
    if (iss !== 256 || ce !== 258) begin
      n_fail++;
      $display("FAIL mid_clear_rerun: got %0d issues comp at %0d required 256/258", iss, ce);
    end
    pulse_load();
    n_checks++;
    if (sad !== 16'd32640) begin
      n_fail++;
      $display("FAIL mid_clear_rerun_sad: got %0d required 32640", sad);
    end
  endtask

  task automatic test_async_abort;
    int iss, last, ce;
    load_mem(0);
    clear_block();
    en = 1'b1;
    repeat (50) tick();
    n_checks++;
    if (addr !== 8'd50) begin
      n_fail++;
      $display("FAIL abort_addr: got %0d required 50", addr);
    end
    #2;
    Mrst = 1'b0;
    #1;
    n_checks++;
    if ({addr, comp, sad, sad_valid} !== '0) begin
      n_fail++;
      $display("FAIL abort_clear: addr=%0d comp=%0b sad=%0d sad_valid=%0b required all 0",
               addr, comp, sad, sad_valid);
    end
    tick();
    en = 1'b0;
    Mrst = 1'b1;
    tick();
    run_block(1'b0, iss, last, ce);
    n_checks++;
    if (iss !== 256 || ce !== 258) begin
      n_fail++;
      $display("FAIL abort_rerun: got %0d issues comp at %0d required 256/258", iss, ce);
    end
    pulse_load();
    n_checks++;
    if (sad !== 16'd32640) begin
      n_fail++;
      $display("FAIL abort_rerun_sad: got %0d required 32640", sad);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_saturation();
    test_stall();
    test_mid_clear();
    test_async_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
